traffic_phase_ctrl: RTL and testbench

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

---
 rtl/traffic_pkg.sv | 43 ++++
 rtl/tick_gen.sv | 34 +++
 rtl/traffic_phase_ctrl.sv | 132 +++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic phase controller: phase states, lamp codes
// and the decode helpers used to drive the two approach heads.
package traffic_pkg;

   localparam int unsigned PHASE_W = 3;
   localparam int unsigned LIGHT_W = 3;

   typedef enum logic [PHASE_W-1:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      EW_GREEN  = 3'd2,
      EW_YELLOW = 3'd3,
      PED_WALK  = 3'd4
   } phase_e;

   // Lamp codes are {red, yellow, green}, one-hot.
   localparam logic [LIGHT_W-1:0] RED = 3'b100;
   localparam logic [LIGHT_W-1:0] YEL = 3'b010;
   localparam logic [LIGHT_W-1:0] GRN = 3'b001;

   function automatic logic [LIGHT_W-1:0] ns_code(input phase_e s);
      logic [LIGHT_W-1:0] c;
      c = RED;
      case (s)
         NS_GREEN:  c = GRN;
         NS_YELLOW: c = YEL;
         default:   c = RED;
      endcase
      return c;
   endfunction

   function automatic logic [LIGHT_W-1:0] ew_code(input phase_e s);
      logic [LIGHT_W-1:0] c;
      c = RED;
      case (s)
         EW_GREEN:  c = GRN;
         EW_YELLOW: c = YEL;
         default:   c = RED;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Timing tick divider: counts 0..TICK_DIV-1 while enabled and pulses tick for
// one cycle on the wrap cycle; holds its count while disabled.
module tick_gen #(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (enable) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Four-phase intersection controller with optional pedestrian walk phase.
// Define PED_REQ_EN to build in the ped_req input, request latch and PED_WALK.
//
// state     | meaning
// ----------+-----------------------------------------------
// NS_GREEN  | north-south green, east-west red
// NS_YELLOW | north-south yellow, east-west red
// EW_GREEN  | east-west green, north-south red
// EW_YELLOW | east-west yellow, north-south red
// PED_WALK  | all red, walk lamp lit (PED_REQ_EN builds only)
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int unsigned TICK_DIV     = 50_000_000,
   parameter int unsigned GREEN_TICKS  = 8,
   parameter int unsigned YELLOW_TICKS = 2,
   parameter int unsigned WALK_TICKS   = 5
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
`ifdef PED_REQ_EN
   input  logic               ped_req,
`endif
   output logic [LIGHT_W-1:0] ns_light,
   output logic [LIGHT_W-1:0] ew_light,
   output logic               ped_walk,
   output logic               ped_pending,
   output logic [PHASE_W-1:0] phase
);

   localparam int unsigned MAX_GY = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
   localparam int unsigned MAX_D  = (MAX_GY > WALK_TICKS) ? MAX_GY : WALK_TICKS;
   localparam int unsigned TW     = $clog2(MAX_D + 1);

   logic               tick;
   phase_e             state_q, state_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic [LIGHT_W-1:0] ns_q, ew_q;
   logic               walk_q;
   logic               pend_q;

   function automatic logic [TW-1:0] dur_m1(input phase_e s);
      logic [TW-1:0] d;
      d = '0;
      case (s)
         NS_GREEN, EW_GREEN:   d = TW'(GREEN_TICKS - 1);
         NS_YELLOW, EW_YELLOW: d = TW'(YELLOW_TICKS - 1);
         PED_WALK:             d = TW'(WALK_TICKS - 1);
         default:              d = '0;
      endcase
      return d;
   endfunction

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .tick   (tick)
   );

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      if (tick) begin
         if (timer_q == dur_m1(state_q)) begin
            timer_d = '0;
            case (state_q)
               NS_GREEN:  state_d = NS_YELLOW;
               NS_YELLOW: state_d = EW_GREEN;
               EW_GREEN:  state_d = EW_YELLOW;
               EW_YELLOW: state_d = pend_q ? PED_WALK : NS_GREEN;
               default:   state_d = NS_GREEN;
            endcase
         end else begin
            timer_d = timer_q + 1'b1;
         end
      end
   end

   // Lamps are decoded from the next state so they update on the same edge as
   // the state register, one clock after the transition tick.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= NS_GREEN;
         timer_q <= '0;
         ns_q    <= GRN;
         ew_q    <= RED;
         walk_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         ns_q    <= ns_code(state_d);
         ew_q    <= ew_code(state_d);
         walk_q  <= (state_d == PED_WALK);
      end
   end

`ifdef PED_REQ_EN
   logic pend_d;
   logic walk_entry;

   // A request arriving on the very cycle the walk begins stays latched.
   always_comb begin
      walk_entry = (state_d == PED_WALK) && (state_q != PED_WALK);
      pend_d     = ped_req | (pend_q & ~walk_entry);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pend_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign ped_walk    = walk_q;
   assign ped_pending = pend_q;
`else
   logic unused_walk;

   assign pend_q      = 1'b0;
   assign unused_walk = walk_q;
   assign ped_walk    = 1'b0;
   assign ped_pending = 1'b0;
`endif

   assign ns_light = ns_q;
   assign ew_light = ew_q;
   assign phase    = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with TICK_DIV=4, GREEN=3, YELLOW=1, WALK=2.
// Pedestrian scenarios run when PED_REQ_EN is defined.
module tb_traffic_phase_ctrl;

   localparam logic [2:0] L_RED = 3'b100;
   localparam logic [2:0] L_YEL = 3'b010;
   localparam logic [2:0] L_GRN = 3'b001;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic       ped_req;
   logic [2:0] ns_light;
   logic [2:0] ew_light;
   logic       ped_walk;
   logic       ped_pending;
   logic [2:0] phase;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   traffic_phase_ctrl #(
      .TICK_DIV     (4),
      .GREEN_TICKS  (3),
      .YELLOW_TICKS (1),
      .WALK_TICKS   (2)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
`ifdef PED_REQ_EN
      .ped_req     (ped_req),
`endif
      .ns_light    (ns_light),
      .ew_light    (ew_light),
      .ped_walk    (ped_walk),
      .ped_pending (ped_pending),
      .phase       (phase)
   );

   function automatic logic [2:0] exp_ns(input logic [2:0] p);
      case (p)
         3'd0:    return L_GRN;
         3'd1:    return L_YEL;
         default: return L_RED;
      endcase
   endfunction

   function automatic logic [2:0] exp_ew(input logic [2:0] p);
      case (p)
         3'd2:    return L_GRN;
         3'd3:    return L_YEL;
         default: return L_RED;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         chk("excl", 32'(ns_light == L_RED || ew_light == L_RED), 32'd1);
      end
   endtask

   // Waits for the phase to change (bounded) and checks length and new outputs.
   task automatic run_phase(input string tag, input logic [2:0] exp_next, input int exp_len);
      logic [2:0] start;
      int n;
      start = phase;
      n = 0;
      do begin
         @(negedge clock);
         n++;
         chk("excl", 32'(ns_light == L_RED || ew_light == L_RED), 32'd1);
      end while (phase == start && n < 200);
      chk({tag, "_len"},   32'(n),        32'(exp_len));
      chk({tag, "_phase"}, 32'(phase),    32'(exp_next));
      chk({tag, "_ns"},    32'(ns_light), 32'(exp_ns(exp_next)));
      chk({tag, "_ew"},    32'(ew_light), 32'(exp_ew(exp_next)));
      chk({tag, "_walk"},  32'(ped_walk), 32'(exp_next == 3'd4));
   endtask

   initial begin
      reset   = 1'b1;
      enable  = 1'b0;
      ped_req = 1'b0;
      @(negedge clock);
      @(negedge clock);
      chk("rst_phase", 32'(phase),       32'd0);
      chk("rst_ns",    32'(ns_light),    32'(L_GRN));
      chk("rst_ew",    32'(ew_light),    32'(L_RED));
      chk("rst_walk",  32'(ped_walk),    32'd0);
      chk("rst_pend",  32'(ped_pending), 32'd0);

      // Full round without requests: 12 + 4 + 12 + 4 = 32 clocks.
      reset  = 1'b0;
      enable = 1'b1;
      run_phase("r1_nsg", 3'd1, 12);
      run_phase("r1_nsy", 3'd2, 4);
      run_phase("r1_ewg", 3'd3, 12);
      run_phase("r1_ewy", 3'd0, 4);
      chk("r1_pend", 32'(ped_pending), 32'd0);

      // Reset in the middle of NS_YELLOW, with a latched request when present.
      run_phase("r2_nsg", 3'd1, 12);
      cycles(1);
`ifdef PED_REQ_EN
      ped_req = 1'b1;
      @(negedge clock);
      ped_req = 1'b0;
      chk("r2_pend_set", 32'(ped_pending), 32'd1);
`endif
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("mrst_phase", 32'(phase),       32'd0);
      chk("mrst_ns",    32'(ns_light),    32'(L_GRN));
      chk("mrst_ew",    32'(ew_light),    32'(L_RED));
      chk("mrst_pend",  32'(ped_pending), 32'd0);
      run_phase("mrst_nsg", 3'd1, 12);

      // Freeze 10 cycles after 5 clocks of EW_GREEN; 7 clocks remain.
      run_phase("fz_nsy", 3'd2, 4);
      cycles(5);
      enable = 1'b0;
      cycles(10);
      chk("fz_phase", 32'(phase),    32'd2);
      chk("fz_ns",    32'(ns_light), 32'(L_RED));
      chk("fz_ew",    32'(ew_light), 32'(L_GRN));
      enable = 1'b1;
      run_phase("fz_ewg", 3'd3, 7);
      run_phase("fz_ewy", 3'd0, 4);

`ifdef PED_REQ_EN
      // Single-cycle request early in NS_GREEN leads to one walk phase.
      cycles(2);
      ped_req = 1'b1;
      @(negedge clock);
      ped_req = 1'b0;
      chk("p1_pend", 32'(ped_pending), 32'd1);
      run_phase("p1_nsg", 3'd1, 9);
      run_phase("p1_nsy", 3'd2, 4);
      run_phase("p1_ewg", 3'd3, 12);
      run_phase("p1_ewy", 3'd4, 4);
      chk("p1_pend_clr", 32'(ped_pending), 32'd0);
      run_phase("p1_walk", 3'd0, 8);

      // Request held through walk entry keeps the latch set for a second walk.
      ped_req = 1'b1;
      run_phase("p2_nsg", 3'd1, 12);
      run_phase("p2_nsy", 3'd2, 4);
      run_phase("p2_ewg", 3'd3, 12);
      run_phase("p2_ewy", 3'd4, 4);
      chk("p2_pend_hold", 32'(ped_pending), 32'd1);
      run_phase("p2_walk", 3'd0, 8);
      ped_req = 1'b0;
      chk("p2_pend_after", 32'(ped_pending), 32'd1);
      run_phase("p3_nsg", 3'd1, 12);
      run_phase("p3_nsy", 3'd2, 4);
      run_phase("p3_ewg", 3'd3, 12);
      run_phase("p3_ewy", 3'd4, 4);
      chk("p3_pend_clr", 32'(ped_pending), 32'd0);
      run_phase("p3_walk", 3'd0, 8);
      chk("p3_pend_end", 32'(ped_pending), 32'd0);
`else
      ped_req = 1'b1;
      run_phase("np_nsg", 3'd1, 12);
      run_phase("np_nsy", 3'd2, 4);
      run_phase("np_ewg", 3'd3, 12);
      run_phase("np_ewy", 3'd0, 4);
      chk("np_pend", 32'(ped_pending), 32'd0);
      ped_req = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
